pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard, cache-miss stall and watchdog control
//
// Purpose: derives per-stage stall/flush controls from load-use, redirect and
// L1 cache-miss conditions, tracks the miss state and raises a sticky watchdog
// flag when a miss stall lasts TIMEOUT cycles. All state updates on the falling
// edge of clk, in step with the pipeline registers.
//
// Optional feature: define PIPE_HAZARD_PERF_EN to build the performance counters;
// otherwise the Perf_* ports are tied to zero.
//
// Ports:
//   clk, rst                    clock (falling-edge state), sync active-high reset
//   ID_Rs, ID_Rt                source registers of the instruction in ID
//   EX_MemRead, EX_WR_out       load in EX and its destination register
//   EX_Redirect                 taken branch/jump resolved in EX
//   IC_Busy, DC_Busy            outstanding L1 I-cache / D-cache miss
//   *_stall                     hold PC, IF/ID, ID/EX, EX/MEM, MEM/WB
//   IF_ID_flush, ID_Flush       zero IF/ID and the ID-stage control bundle
//   Miss_state                  0=RUN, 1=IMISS, 2=DMISS
//   Timeout_err                 sticky watchdog flag
//   Perf_stall/lduse/redirect   saturating event counters
module pipe_hazard_ctrl #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ID_Rs,
   input  logic [4:0]  ID_Rt,
   input  logic        EX_MemRead,
   input  logic [4:0]  EX_WR_out,
   input  logic        EX_Redirect,
   input  logic        IC_Busy,
   input  logic        DC_Busy,
   output logic        PC_stall,
   output logic        IF_ID_stall,
   output logic        ID_EX_stall,
   output logic        EX_MEM_stall,
   output logic        MEM_WB_stall,
   output logic        IF_ID_flush,
   output logic        ID_Flush,
   output logic [1:0]  Miss_state,
   output logic        Timeout_err,
   output logic [31:0] Perf_stall,
   output logic [31:0] Perf_lduse,
   output logic [31:0] Perf_redirect
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      IMISS = 2'd1,
      DMISS = 2'd2
   } state_t;

   localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

   state_t      state;
   state_t      state_next;
   logic [15:0] wait_cnt;
   logic [15:0] wait_cnt_next;
   logic        gs;
   logic        lu;
   logic        rd;
   logic        lu_bubble;

   assign gs = IC_Busy | DC_Busy;
   assign lu = EX_MemRead & (EX_WR_out != 5'd0) &
               ((EX_WR_out == ID_Rs) | (EX_WR_out == ID_Rt));
   // A redirect is held in EX during a miss and only acts once the miss clears.
   assign rd = EX_Redirect & ~gs;
   // Load-use bubble only when neither a miss nor a redirect takes precedence.
   assign lu_bubble = lu & ~rd & ~gs;

   always_comb begin : hazard_outputs
      PC_stall     = gs | lu_bubble;
      IF_ID_stall  = gs | lu_bubble;
      ID_EX_stall  = gs;
      EX_MEM_stall = gs;
      MEM_WB_stall = gs;
      IF_ID_flush  = rd;
      ID_Flush     = rd | lu_bubble;
   end

   // State register
   always_ff @(negedge clk) begin
      if (rst) begin
         state       <= RUN;
         wait_cnt    <= 16'd0;
         Timeout_err <= 1'b0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
         if (wait_cnt_next == TIMEOUT_CNT) begin
            Timeout_err <= 1'b1;
         end
      end
   end

   // Next state: D-miss wins over I-miss; the counter survives IMISS<->DMISS.
   always_comb begin : next_state
      state_next    = RUN;
      wait_cnt_next = 16'd0;
      if (DC_Busy) begin
         state_next = DMISS;
      end else if (IC_Busy) begin
         state_next = IMISS;
      end
      if (state_next != RUN) begin
         wait_cnt_next = (wait_cnt == 16'hFFFF) ? wait_cnt : wait_cnt + 16'd1;
      end
   end

   // State outputs
   always_comb begin : state_outputs
      Miss_state = state;
   end

`ifdef PIPE_HAZARD_PERF_EN
   always_ff @(negedge clk) begin
      if (rst) begin
         Perf_stall    <= 32'd0;
         Perf_lduse    <= 32'd0;
         Perf_redirect <= 32'd0;
      end else begin
         if (gs && (Perf_stall != 32'hFFFF_FFFF)) begin
            Perf_stall <= Perf_stall + 32'd1;
         end
         if (lu_bubble && (Perf_lduse != 32'hFFFF_FFFF)) begin
            Perf_lduse <= Perf_lduse + 32'd1;
         end
         if (rd && (Perf_redirect != 32'hFFFF_FFFF)) begin
            Perf_redirect <= Perf_redirect + 32'd1;
         end
      end
   end
`else
   assign Perf_stall    = 32'd0;
   assign Perf_lduse    = 32'd0;
   assign Perf_redirect = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;

   localparam int TMO = 4;

   logic        clk;
   logic        rst;
   logic [4:0]  ID_Rs, ID_Rt, EX_WR_out;
   logic        EX_MemRead, EX_Redirect, IC_Busy, DC_Busy;
   logic        PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall, MEM_WB_stall;
   logic        IF_ID_flush, ID_Flush;
   logic [1:0]  Miss_state;
   logic        Timeout_err;
   logic [31:0] Perf_stall, Perf_lduse, Perf_redirect;

   pipe_hazard_ctrl #(.TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .ID_Rs(ID_Rs), .ID_Rt(ID_Rt),
      .EX_MemRead(EX_MemRead), .EX_WR_out(EX_WR_out), .EX_Redirect(EX_Redirect),
      .IC_Busy(IC_Busy), .DC_Busy(DC_Busy),
      .PC_stall(PC_stall), .IF_ID_stall(IF_ID_stall), .ID_EX_stall(ID_EX_stall),
      .EX_MEM_stall(EX_MEM_stall), .MEM_WB_stall(MEM_WB_stall),
      .IF_ID_flush(IF_ID_flush), .ID_Flush(ID_Flush), .Miss_state(Miss_state),
      .Timeout_err(Timeout_err), .Perf_stall(Perf_stall), .Perf_lduse(Perf_lduse),
      .Perf_redirect(Perf_redirect)
   );

   initial clk = 1'b1;
   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [6:0]  hz;   // {PC,IF_ID,ID_EX,EX_MEM,MEM_WB stall, IF_ID_flush, ID_Flush}
      logic [1:0]  ms;
      logic        to;
      logic [31:0] ps, pl, pr;
   } exp_t;

   exp_t        sb[$];
   int          vectors = 0;
   int          miscompares = 0;
   logic [1:0]  m_state;
   int          m_cnt;
   logic        m_to;
   logic [31:0] m_ps, m_pl, m_pr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic mr,
                        input logic [4:0] wr, input logic redir, input logic ic,
                        input logic dc);
      ID_Rs = rs; ID_Rt = rt; EX_MemRead = mr; EX_WR_out = wr;
      EX_Redirect = redir; IC_Busy = ic; DC_Busy = dc;
   endtask

   function automatic logic [6:0] exp_hz();
      logic g, l, r;
      g = IC_Busy | DC_Busy;
      l = EX_MemRead && (EX_WR_out != 5'd0) && (EX_WR_out == ID_Rs || EX_WR_out == ID_Rt);
      r = EX_Redirect && !g;
      if (g) return 7'b1111100;
      if (r) return 7'b0000011;
      if (l) return 7'b1100001;
      return 7'b0000000;
   endfunction

   task automatic model_step();
      logic [1:0] ns;
      logic       g, l, r;
      if (rst) begin
         m_state = 2'd0; m_cnt = 0; m_to = 1'b0;
         m_ps = 32'd0; m_pl = 32'd0; m_pr = 32'd0;
      end else begin
         ns = DC_Busy ? 2'd2 : (IC_Busy ? 2'd1 : 2'd0);
         m_cnt = (ns == 2'd0) ? 0 : ((m_cnt < 65535) ? m_cnt + 1 : m_cnt);
         if (m_cnt == TMO) m_to = 1'b1;
         m_state = ns;
         g = IC_Busy | DC_Busy;
         l = EX_MemRead && (EX_WR_out != 5'd0) && (EX_WR_out == ID_Rs || EX_WR_out == ID_Rt);
         r = EX_Redirect && !g;
`ifdef PIPE_HAZARD_PERF_EN
         if (g && m_ps != 32'hFFFF_FFFF) m_ps++;
         if (l && !r && !g && m_pl != 32'hFFFF_FFFF) m_pl++;
         if (r && m_pr != 32'hFFFF_FFFF) m_pr++;
`else
         if (g || l || r) begin
            m_ps = 32'd0;
         end
`endif
      end
   endtask

   // One clock: push expectation, compare at the rising edge, then the state edge.
   task automatic cyc(input string tag);
      exp_t e;
      e.tag = tag; e.hz = exp_hz(); e.ms = m_state; e.to = m_to;
      e.ps = m_ps; e.pl = m_pl; e.pr = m_pr;
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      chk({e.tag, "_hz"}, {PC_stall, IF_ID_stall, ID_EX_stall, EX_MEM_stall,
                           MEM_WB_stall, IF_ID_flush, ID_Flush}, e.hz);
      chk({e.tag, "_ms"}, Miss_state, e.ms);
      chk({e.tag, "_to"}, Timeout_err, e.to);
      chk({e.tag, "_ps"}, Perf_stall, e.ps);
      chk({e.tag, "_pl"}, Perf_lduse, e.pl);
      chk({e.tag, "_pr"}, Perf_redirect, e.pr);
      @(negedge clk);
      model_step();
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "bench time limit");
   end

   logic [1:0] ovl_seq [8];
   logic [31:0] perf_exp;

   initial begin
      ovl_seq = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd0};
      rst = 1'b1;
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      @(negedge clk); @(negedge clk);
      model_step();
      #1;

      // Reset: combinational stall still follows IC_Busy, state reads RUN.
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      cyc("rst_ic");
      chk("rst_ms_after", Miss_state, 2'd0);
      rst = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("idle");

      // Load-use via rt, lasting exactly one cycle, then the load moves on.
      drive(5'd3, 5'd8, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
      cyc("lu_rt");
      drive(5'd8, 5'd8, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("lu_done");
      drive(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("lu_r0");
      drive(5'd5, 5'd9, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
      cyc("lu_rs");
      drive(5'd5, 5'd9, 1'b1, 5'd6, 1'b0, 1'b0, 1'b0);
      cyc("lu_nomatch");

      // Redirect overrides load-use.
      drive(5'd3, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
      cyc("rd_lu");
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("rd_after");

      // D-miss of 5 cycles from a clean reset.
      rst = 1'b1; cyc("rst1"); rst = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc("dmiss");
         chk("dmiss_ms", Miss_state, 2'd2);
      end
`ifdef PIPE_HAZARD_PERF_EN
      perf_exp = 32'd5;
`else
      perf_exp = 32'd0;
`endif
      chk("dmiss_perf", Perf_stall, perf_exp);
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("dmiss_end");
      chk("dmiss_run", Miss_state, 2'd0);

      // Overlapping misses.
      rst = 1'b1; cyc("rst2"); rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, (i <= 3), (i >= 2 && i <= 6));
         cyc("ovl");
         chk($sformatf("ovl_seq%0d", i), Miss_state, ovl_seq[i]);
      end

      // IMISS->DMISS keeps counting: 2 + 2 cycles reach TIMEOUT=4.
      rst = 1'b1; cyc("rst3"); rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, (i < 2), (i >= 2));
         cyc("noclr");
      end
      chk("noclr_to", Timeout_err, 1'b1);

      // Watchdog: sets on the 4th edge, sticky, cleared by reset.
      rst = 1'b1; cyc("rst4"); rst = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 10; i++) begin
         cyc("wd");
         chk($sformatf("wd_to%0d", i), Timeout_err, (i >= 3));
      end
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("wd_drop");
      cyc("wd_drop2");
      chk("wd_sticky", Timeout_err, 1'b1);
      rst = 1'b1; cyc("wd_rst"); rst = 1'b0;
      chk("wd_clear", Timeout_err, 1'b0);

      // Redirect held during a D-miss acts in the first cycle after it.
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) cyc("rd_miss");
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("rd_release_flush", {IF_ID_flush, ID_Flush, PC_stall}, 3'b110);
      cyc("rd_release");
      drive(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      cyc("final_idle");

      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
